// File: rtl/rep_sequencer_pkg.sv
// Shared decode definitions for the REP string-instruction sequencer:
// FSM state encoding and the constant ECX writeback descriptor.
package rep_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_ECX = 3'd1,
      CHECK    = 3'd2,
      ISSUE    = 3'd3,
      YIELD    = 3'd4
   } state_t;

   localparam logic [2:0] ECX_REG_ID    = 3'b001;
   localparam logic [2:0] WB_SIZE_DWORD = 3'd3;

endpackage

// File: rtl/rep_counter.sv
// Loadable 32-bit down-counter holding the remaining REP iteration count.
module rep_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_value,
   input  logic        dec,
   output logic [31:0] count,
   output logic        is_zero,
   output logic        is_one
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - 32'd1;
      end
   end

   assign is_zero = (count == 32'd0);
   assign is_one  = (count == 32'd1);

endmodule

// File: rtl/rep_sequencer.sv
// Holds one REP string instruction between decode stages 0 and 1, issuing one
// stage-1 transaction per iteration with ECX writeback and interrupt yielding.
module rep_sequencer
   import rep_sequencer_pkg::*;
#(
   parameter int unsigned IADDRW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_rep,
   input  logic              in_string_op,
   input  logic [IADDRW-1:0] in_pc,
   input  logic [31:0]       ecx_register,
   input  logic              busy_ahead,
   input  logic              pending_int,
   output logic              hold_int,
   output logic              int_window,
   output logic [IADDRW-1:0] resume_pc,
   input  logic              int_taken,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              wb_valid,
   output logic [2:0]        wb_reg,
   output logic [31:0]       wb_data,
   output logic [2:0]        wb_size,
   output logic [31:0]       iter_count
);

   state_t      state, next_state;
   logic [31:0] count;
   logic        cnt_zero, cnt_one;
   logic        load, dec;
   logic        rep_instr;

   rep_counter u_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (ecx_register),
      .dec        (dec),
      .count      (count),
      .is_zero    (cnt_zero),
      .is_one     (cnt_one)
   );

   assign rep_instr  = in_valid & in_rep & in_string_op;
   assign wb_reg     = ECX_REG_ID;
   assign wb_size    = WB_SIZE_DWORD;
   assign iter_count = count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      dec        = 1'b0;
      in_ready   = 1'b0;
      hold_int   = 1'b0;
      int_window = 1'b0;
      resume_pc  = '0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      wb_valid   = 1'b0;
      wb_data    = '0;

      case (state)
         IDLE: begin
            out_last = 1'b1;
            if (rep_instr) begin
               next_state = WAIT_ECX;
            end else begin
               out_valid = in_valid;
               in_ready  = out_ready;
            end
         end
         WAIT_ECX: begin
            hold_int = 1'b1;
            if (!busy_ahead) next_state = CHECK;
         end
         CHECK: begin
            hold_int = 1'b1;
            load     = 1'b1;
            if (ecx_register == 32'd0) begin
               in_ready   = 1'b1;
               next_state = IDLE;
            end else begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            out_last = cnt_one;
            if (pending_int) begin
               next_state = YIELD;
            end else begin
               // cnt_zero is unreachable here; gating on it keeps count from wrapping
               out_valid = ~cnt_zero;
               if (out_ready && !cnt_zero) begin
                  dec      = 1'b1;
                  wb_valid = 1'b1;
                  wb_data  = count - 32'd1;
                  if (cnt_one) begin
                     in_ready   = 1'b1;
                     next_state = IDLE;
                  end
               end
            end
         end
         YIELD: begin
            int_window = 1'b1;
            resume_pc  = in_pc;
            if (int_taken) begin
               in_ready   = 1'b1;
               next_state = IDLE;
            end else if (!pending_int) begin
               next_state = ISSUE;
            end
         end
         default: next_state = IDLE;
      endcase

      // flush cancels any handshake or writeback in its cycle and freezes count
      if (flush) begin
         load      = 1'b0;
         dec       = 1'b0;
         in_ready  = 1'b0;
         out_valid = 1'b0;
         wb_valid  = 1'b0;
         wb_data   = '0;
      end

      if (reset) begin
         in_ready   = 1'b0;
         hold_int   = 1'b0;
         int_window = 1'b0;
         resume_pc  = '0;
         out_valid  = 1'b0;
         out_last   = 1'b0;
         wb_valid   = 1'b0;
         wb_data    = '0;
      end
   end

endmodule

// File: tb/tb_rep_sequencer.sv
// Bench for rep_sequencer: vector table for pass-through, directed REP sequences,
// and a writeback scoreboard checked whenever wb_valid is seen.
module tb_rep_sequencer;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_rep, in_string_op;
   logic [31:0] in_pc, ecx_register;
   logic        busy_ahead, pending_int, int_taken, out_ready;
   logic        in_ready, hold_int, int_window, out_valid, out_last, wb_valid;
   logic [31:0] resume_pc, wb_data, iter_count;
   logic [2:0]  wb_reg, wb_size;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [31:0] exp_wb[$];

   always #5 clk = ~clk;

   rep_sequencer #(.IADDRW(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rep       (in_rep),
      .in_string_op (in_string_op),
      .in_pc        (in_pc),
      .ecx_register (ecx_register),
      .busy_ahead   (busy_ahead),
      .pending_int  (pending_int),
      .hold_int     (hold_int),
      .int_window   (int_window),
      .resume_pc    (resume_pc),
      .int_taken    (int_taken),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .wb_valid     (wb_valid),
      .wb_reg       (wb_reg),
      .wb_data      (wb_data),
      .wb_size      (wb_size),
      .iter_count   (iter_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writeback scoreboard
   always @(negedge clk) begin
      if (!reset && wb_valid) begin
         if (exp_wb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got wb_data %0h expected no writeback", wb_data);
         end else begin
            check("wb_data", wb_data, exp_wb.pop_front());
         end
      end
   end

   // Accept a REP instruction and advance to the first ISSUE cycle
   task automatic enter_issue(input logic [31:0] ecx, input logic [31:0] pc);
      in_valid = 1'b1; in_rep = 1'b1; in_string_op = 1'b1;
      in_pc = pc; ecx_register = ecx;
      #1;
      check("accept_in_ready", in_ready, 1'b0);
      check("accept_out_valid", out_valid, 1'b0);
      tick();
      check("wait_hold_int", hold_int, 1'b1);
      tick();
      check("check_hold_int", hold_int, 1'b1);
      check("check_in_ready", in_ready, (ecx == 32'd0));
      check("check_out_valid", out_valid, 1'b0);
      check("check_wb_valid", wb_valid, 1'b0);
      tick();
   endtask

   typedef struct {
      logic v, rep, sop, ordy;
      logic e_ov, e_ir, e_last, e_wb;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rep = 1'b0; in_string_op = 1'b0;
      in_pc = '0; ecx_register = '0; busy_ahead = 1'b0; pending_int = 1'b0;
      int_taken = 1'b0; out_ready = 1'b1;
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_hold_int", hold_int, 1'b0);
      check("rst_iter_count", iter_count, 32'd0);
      check("rst_wb_reg", wb_reg, 3'b001);
      check("rst_wb_size", wb_size, 3'd3);
      reset = 1'b0;
      tick();

      // Pass-through vectors
      for (int i = 0; i < 6; i++) begin
         in_valid = vecs[i].v; in_rep = vecs[i].rep;
         in_string_op = vecs[i].sop; out_ready = vecs[i].ordy;
         #1;
         check($sformatf("pt%0d_out_valid", i), out_valid, vecs[i].e_ov);
         check($sformatf("pt%0d_in_ready", i), in_ready, vecs[i].e_ir);
         check($sformatf("pt%0d_out_last", i), out_last, vecs[i].e_last);
         check($sformatf("pt%0d_wb_valid", i), wb_valid, vecs[i].e_wb);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();

      // REP ECX=3
      exp_wb.push_back(32'd2); exp_wb.push_back(32'd1); exp_wb.push_back(32'd0);
      enter_issue(32'd3, 32'h100);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("e3_out_valid", out_valid, 1'b1);
         check("e3_out_last", out_last, (i == 2));
         check("e3_in_ready", in_ready, (i == 2));
         check("e3_iter_count", iter_count, 32'(3 - i));
         check("e3_hold_int", hold_int, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("e3_idle_out_valid", out_valid, 1'b0);
      check("e3_idle_out_last", out_last, 1'b1);
      tick();

      // REP ECX=0
      enter_issue(32'd0, 32'h200);
      in_valid = 1'b0;
      #1;
      check("e0_out_valid", out_valid, 1'b0);
      check("e0_idle_out_last", out_last, 1'b1);
      tick();

      // busy_ahead stall, ECX changes from 7 to 2 during it
      busy_ahead = 1'b1;
      in_valid = 1'b1; in_rep = 1'b1; in_string_op = 1'b1; ecx_register = 32'd7;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 2) ecx_register = 32'd2;
         #1;
         check("stall_hold_int", hold_int, 1'b1);
         check("stall_out_valid", out_valid, 1'b0);
         tick();
      end
      busy_ahead = 1'b0;
      tick();
      tick();
      exp_wb.push_back(32'd1); exp_wb.push_back(32'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         check("stall_iter_count", iter_count, 32'(2 - i));
         check("stall_issue_valid", out_valid, 1'b1);
         check("stall_in_ready", in_ready, (i == 1));
         tick();
      end
      in_valid = 1'b0;
      #1;
      check("stall_idle", out_last, 1'b1);
      tick();

      // Interrupt after first of five iterations
      exp_wb.push_back(32'd4);
      enter_issue(32'd5, 32'h0000_1234);
      #1;
      check("int_first_valid", out_valid, 1'b1);
      tick();
      pending_int = 1'b1;
      #1;
      check("int_suppress_valid", out_valid, 1'b0);
      check("int_issue_hold", hold_int, 1'b0);
      tick();
      check("int_window", int_window, 1'b1);
      check("int_resume_pc", resume_pc, 32'h0000_1234);
      check("int_yield_valid", out_valid, 1'b0);
      check("int_yield_hold", hold_int, 1'b0);
      check("int_yield_count", iter_count, 32'd4);
      int_taken = 1'b1;
      #1;
      check("int_taken_in_ready", in_ready, 1'b1);
      tick();
      int_taken = 1'b0; pending_int = 1'b0; in_valid = 1'b0;
      #1;
      check("int_idle_window", int_window, 1'b0);
      check("int_idle_last", out_last, 1'b1);
      tick();

      // Interrupt on the last iteration, then pending_int withdrawn
      enter_issue(32'd1, 32'h300);
      pending_int = 1'b1;
      #1;
      check("last_int_valid", out_valid, 1'b0);
      check("last_int_out_last", out_last, 1'b1);
      tick();
      check("last_int_window", int_window, 1'b1);
      check("last_int_count", iter_count, 32'd1);
      pending_int = 1'b0;
      #1;
      check("last_int_no_ready", in_ready, 1'b0);
      tick();
      exp_wb.push_back(32'd0);
      check("last_reissue_valid", out_valid, 1'b1);
      check("last_reissue_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      tick();

      // out_ready backpressure, two transfers, then flush at count 3
      out_ready = 1'b0;
      enter_issue(32'd5, 32'h400);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_wb_valid", wb_valid, 1'b0);
      tick();
      check("bp_count_held", iter_count, 32'd5);
      out_ready = 1'b1;
      exp_wb.push_back(32'd4); exp_wb.push_back(32'd3);
      tick();
      tick();
      flush = 1'b1;
      #1;
      check("flush_wb_valid", wb_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_count", iter_count, 32'd3);
      check("flush_idle", out_last, 1'b1);
      tick();

      // ECX=0xFFFFFFFF iterates; async reset mid-ISSUE
      exp_wb.push_back(32'hFFFF_FFFE);
      enter_issue(32'hFFFF_FFFF, 32'h500);
      #1;
      check("max_out_valid", out_valid, 1'b1);
      tick();
      check("max_count", iter_count, 32'hFFFF_FFFE);
      #1;
      reset = 1'b1;
      #1;
      check("async_out_valid", out_valid, 1'b0);
      check("async_out_last", out_last, 1'b0);
      check("async_wb_valid", wb_valid, 1'b0);
      check("async_iter_count", iter_count, 32'd0);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      tick();
      check("post_reset_idle", out_last, 1'b1);
      tick();

      check("scoreboard_empty", exp_wb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
